// File: rtl/gx400_obj_dma_seq_if.sv
// Object-RAM read port, line-buffer write port and CPU arbitration handshake
// shared between the sprite DMA sequencer and its memories.
interface gx400_obj_dma_seq_if #(
    parameter int unsigned SRC_AW = 11,
    parameter int unsigned DST_AW = 10
);
    logic [SRC_AW-1:0] src_addr;
    logic              src_rd;
    logic [15:0]       src_data;
    logic [DST_AW-1:0] dst_addr;
    logic [15:0]       dst_data;
    logic              dst_we;
    logic              cpu_req;
    logic              cpu_gnt;

    modport master (
        output src_addr, src_rd, dst_addr, dst_data, dst_we, cpu_gnt,
        input  src_data, cpu_req
    );

    modport slave (
        input  src_addr, src_rd, dst_addr, dst_data, dst_we, cpu_gnt,
        output src_data, cpu_req
    );
endinterface

// File: rtl/gx400_obj_dma_seq.sv
// Vblank sprite copy sequencer: steps the K005292 object counter, copies each object's words
// from object RAM into the line-engine buffer, and shares object RAM with the CPU.
module gx400_obj_dma_seq #(
    parameter int unsigned OBJ_COUNT     = 128,
    parameter int unsigned WORDS_PER_OBJ = 8,
    parameter int unsigned SRC_AW        = 11
) (
    input  logic                       i_MCLK,
    input  logic                       i_RST_n,
    input  logic                       i_CEN6,
    input  logic                       i_VBLANK_n,
    input  logic                       i_DMA_EN,
    input  logic [7:0]                 i_OBJ_CNTR,
    output logic                       o_DMA_n,
    output logic                       o_ORINC,
    gx400_obj_dma_seq_if.master        bus,
    output logic                       o_BUSY,
    output logic                       o_DONE,
    output logic                       o_ABORT,
    output logic                       o_SEQ_ERR
);
    localparam int unsigned OBJ_W   = $clog2(OBJ_COUNT);
    localparam int unsigned WORD_SH = $clog2(WORDS_PER_OBJ);
    localparam int unsigned WORD_W  = (WORD_SH == 0) ? 1 : WORD_SH;
    localparam int unsigned DST_AW  = OBJ_W + WORD_SH;

    typedef enum logic [2:0] {
        StIdle, StClr, StSettle, StRd, StWr, StInc, StCpu, StFin
    } state_t;

    state_t              state_q, state_d;
    logic                vblank_q;
    logic                pending_q, pending_d;
    logic [OBJ_W-1:0]    obj_idx_q, obj_idx_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [SRC_AW-1:0]   src_addr_q, src_addr_d;
    logic [DST_AW-1:0]   dst_addr_q, dst_addr_d;
    logic [15:0]         dst_data_q, dst_data_d;
    logic                dst_we_q, dst_we_d;
    logic                gnt_q, gnt_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;
    logic                seq_err_q, seq_err_d;
    logic                vblank_fall;
    logic                abortable;

    function automatic logic [SRC_AW-1:0] src_addr_f(input logic [7:0] cntr,
                                                     input logic [WORD_W-1:0] word);
        return (SRC_AW'(cntr) << WORD_SH) | SRC_AW'(word);
    endfunction

    assign vblank_fall = vblank_q & ~i_VBLANK_n;
    assign abortable   = state_q inside {StClr, StSettle, StRd, StWr, StInc, StCpu};

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        obj_idx_d  = obj_idx_q;
        word_d     = word_q;
        src_addr_d = src_addr_q;
        dst_addr_d = dst_addr_q;
        dst_data_d = dst_data_q;
        dst_we_d   = dst_we_q;
        gnt_d      = gnt_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        seq_err_d  = seq_err_q;

        // Edges seen outside IDLE (including the FIN/abort cycle) are dropped.
        if (state_q == StIdle && vblank_fall && i_DMA_EN) begin
            pending_d = 1'b1;
        end

        if (abortable && i_VBLANK_n) begin
            // Grant is left alone so a CPU caught in StCpu keeps the RAM until it lets go.
            state_d  = StIdle;
            abort_d  = 1'b1;
            dst_we_d = 1'b0;
        end else if (i_CEN6) begin
            dst_we_d = 1'b0;
            unique case (state_q)
                StIdle: begin
                    gnt_d = bus.cpu_req;
                    if (pending_q && !gnt_q) begin
                        gnt_d     = 1'b0;
                        pending_d = 1'b0;
                        obj_idx_d = '0;
                        word_d    = '0;
                        seq_err_d = 1'b0;
                        state_d   = StClr;
                    end
                end
                StClr: state_d = StSettle;
                StSettle: begin
                    src_addr_d = src_addr_f(i_OBJ_CNTR, word_q);
                    if (word_q == '0 && i_OBJ_CNTR != 8'(obj_idx_q)) begin
                        seq_err_d = 1'b1;
                    end
                    state_d = StRd;
                end
                StRd: state_d = StWr;
                StWr: begin
                    dst_data_d = bus.src_data;
                    dst_we_d   = 1'b1;
                    dst_addr_d = (DST_AW'(obj_idx_q) << WORD_SH) | DST_AW'(word_q);
                    if (word_q != WORD_W'(WORDS_PER_OBJ - 1)) begin
                        word_d     = word_q + WORD_W'(1);
                        src_addr_d = src_addr_f(i_OBJ_CNTR, word_q + WORD_W'(1));
                        state_d    = StRd;
                    end else begin
                        word_d  = '0;
                        state_d = StInc;
                    end
                end
                StInc: begin
                    obj_idx_d = obj_idx_q + OBJ_W'(1);
                    if (obj_idx_q == OBJ_W'(OBJ_COUNT - 1)) begin
                        state_d = StFin;
                    end else if (bus.cpu_req) begin
                        gnt_d   = 1'b1;
                        state_d = StCpu;
                    end else begin
                        state_d = StSettle;
                    end
                end
                StCpu: begin
                    if (!bus.cpu_req) begin
                        gnt_d   = 1'b0;
                        state_d = StSettle;
                    end
                end
                StFin: begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_MCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q    <= StIdle;
            vblank_q   <= 1'b0;
            pending_q  <= 1'b0;
            obj_idx_q  <= '0;
            word_q     <= '0;
            src_addr_q <= '0;
            dst_addr_q <= '0;
            dst_data_q <= '0;
            dst_we_q   <= 1'b0;
            gnt_q      <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            seq_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vblank_q   <= i_VBLANK_n;
            pending_q  <= pending_d;
            obj_idx_q  <= obj_idx_d;
            word_q     <= word_d;
            src_addr_q <= src_addr_d;
            dst_addr_q <= dst_addr_d;
            dst_data_q <= dst_data_d;
            dst_we_q   <= dst_we_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            seq_err_q  <= seq_err_d;
        end
    end

    assign o_DMA_n      = (state_q != StClr);
    assign o_ORINC      = (state_q != StInc);
    assign bus.src_rd   = (state_q == StRd);
    assign bus.src_addr = src_addr_q;
    assign bus.dst_addr = dst_addr_q;
    assign bus.dst_data = dst_data_q;
    assign bus.dst_we   = dst_we_q;
    assign bus.cpu_gnt  = gnt_q;
    assign o_BUSY       = (state_q != StIdle);
    assign o_DONE       = done_q;
    assign o_ABORT      = abort_q;
    assign o_SEQ_ERR    = seq_err_q;
endmodule
